// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and request checks for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_t;

  // Stores only know SB/SH/SW; loads additionally know the unsigned byte/half forms.
  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    if (write) return (f3 > F3_SW);
    return !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

  // Size is carried in funct3[1:0] for both signed and unsigned forms.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case ({1'b0, f3[1:0]})
      F3_LH:   return addr_lo[0];
      F3_LW:   return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// rtl/lsu_load_format.sv - selects and extends the loaded byte/half/word from the memory word
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane picked by addr[1:0], half lane by addr[1]
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Sign- or zero-extend according to the load kind
  always_comb begin
    o_data = 32'h0;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0, w_half};
      F3_LW:   o_data = i_rdata;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - checks core memory requests and runs them on a byte-enabled memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic [1:0]  o_resp_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  lsu_state_t  r_state;
  lsu_err_t    r_err;
  logic [CW-1:0] r_cnt;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic [31:0] w_load_data;
  logic [3:0]  w_be;
  logic [31:0] w_lane_wdata;

  lsu_load_format u_load_format (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_rdata   (i_mem_rdata),
    .o_data    (w_load_data)
  );

  // Byte enables and replicated store lanes from the latched request; loads share the mask
  always_comb begin
    w_be         = 4'b1111;
    w_lane_wdata = r_wdata;
    case ({1'b0, r_funct3[1:0]})
      F3_SB: begin
        w_be         = 4'b0001 << r_addr[1:0];
        w_lane_wdata = {4{r_wdata[7:0]}};
      end
      F3_SH: begin
        w_be         = 4'b0011 << {r_addr[1], 1'b0};
        w_lane_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be         = 4'b1111;
        w_lane_wdata = r_wdata;
      end
    endcase
  end

  // Request FSM: accept and check in IDLE, wait for ack or timeout in BUSY, pulse in RESP
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_err    <= ERR_NONE;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_write  <= i_req_write;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_cnt    <= '0;
            r_rdata  <= 32'h0;
            if (f3_illegal(i_req_write, i_req_funct3)) begin
              r_err   <= ERR_ILLEGAL;
              r_state <= RESP;
            end else if (f3_misaligned(i_req_funct3, i_req_addr[1:0])) begin
              r_err   <= ERR_MISALIGN;
              r_state <= RESP;
            end else begin
              r_err   <= ERR_NONE;
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (i_mem_rvalid) begin
            r_err   <= ERR_NONE;
            r_rdata <= r_write ? 32'h0 : w_load_data;
            r_state <= RESP;
          end else if (r_cnt == CNT_MAX) begin
            r_err   <= ERR_TIMEOUT;
            r_rdata <= 32'h0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = (r_state == RESP);
  assign o_resp_err   = r_err;
  assign o_resp_rdata = r_rdata;
  assign o_mem_req    = (r_state == BUSY);
  assign o_mem_we     = (r_state == BUSY) && r_write;
  assign o_mem_addr   = {r_addr[31:2], 2'b00};
  assign o_mem_be     = w_be;
  assign o_mem_wdata  = w_lane_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;        // busy cycle index that gets rvalid; -1 = never
    logic        hold;     // keep req_valid high and wiggle req_addr while busy
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_req;  // cycles mem_req is high
    int          exp_lat;  // cycles from accept to resp_valid
  } vec_t;

  vec_t vecs[16];

  load_store_unit #(.TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_be     (mem_be),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int req_cnt;
    int lat;
    bit got;
    bit stable;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_be;
    logic        c_we;
    logic [1:0]  c_err;
    req_cnt = 0; lat = 0; got = 0; stable = 1;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 0; c_err = '0; c_rdata = '0;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.write; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; mem_rdata = v.rdata;
    @(posedge clk);
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (v.hold) req_addr = ~v.addr; else req_valid = 1'b0;
      if (resp_valid) begin
        got = 1; lat = i; c_err = resp_err; c_rdata = resp_rdata;
        req_valid = 1'b0;
      end else if (mem_req) begin
        if (req_cnt == 0) begin
          c_addr = mem_addr; c_wdata = mem_wdata; c_be = mem_be; c_we = mem_we;
        end else if (c_addr !== mem_addr || c_wdata !== mem_wdata || c_be !== mem_be || c_we !== mem_we) begin
          stable = 0;
        end
        if (req_ready) stable = 0;
        if (v.k >= 0 && req_cnt == v.k) mem_rvalid = 1'b1;
        req_cnt++;
      end
    end
    req_valid = 1'b0;
    mem_rvalid = 1'b0;
    chk($sformatf("v%0d_got_resp", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_req_cycles", idx), 32'(req_cnt), 32'(v.exp_req));
    chk($sformatf("v%0d_err", idx), 32'(c_err), 32'(v.exp_err));
    chk($sformatf("v%0d_rdata", idx), c_rdata, v.exp_rdata);
    if (v.exp_req > 0) begin
      chk($sformatf("v%0d_be", idx), 32'(c_be), 32'(v.exp_be));
      chk($sformatf("v%0d_addr", idx), c_addr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_wdata", idx), c_wdata, v.exp_wdata);
      chk($sformatf("v%0d_we", idx), 32'(c_we), 32'(v.write));
      chk($sformatf("v%0d_stable", idx), 32'(stable), 32'd1);
    end
    @(negedge clk);
    chk($sformatf("v%0d_pulse_one", idx), 32'(resp_valid), 32'd0);
    chk($sformatf("v%0d_ready_after", idx), 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit quiet;
    //            wr  f3    addr          wdata         rdata         k  hold err    exp_rdata     be       exp_wdata    req lat
    vecs[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 1'b0, 2'b00, 32'h0,        4'b1111, 32'hDEADBEEF, 1, 2};
    vecs[1]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 2'b00, 32'hDEADBEEF, 4'b1111, 32'h0,        1, 2};
    vecs[2]  = '{1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0,        1, 1'b0, 2'b00, 32'h0,        4'b1000, 32'hA5A5A5A5, 2, 3};
    vecs[3]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'hA5000000, 0, 1'b0, 2'b00, 32'hFFFFFFA5, 4'b1000, 32'h0,        1, 2};
    vecs[4]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'hA5000000, 2, 1'b0, 2'b00, 32'h000000A5, 4'b1000, 32'h0,        3, 4};
    vecs[5]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80010000, 0, 1'b0, 2'b00, 32'hFFFF8001, 4'b1100, 32'h0,        1, 2};
    vecs[6]  = '{1'b0, 3'd5, 32'h102, 32'h0,        32'h80010000, 0, 1'b0, 2'b00, 32'h00008001, 4'b1100, 32'h0,        1, 2};
    vecs[7]  = '{1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        0, 1'b0, 2'b01, 32'h0,        4'b0000, 32'h0,        0, 1};
    vecs[8]  = '{1'b1, 3'd1, 32'h205, 32'h1234,     32'h0,        0, 1'b0, 2'b01, 32'h0,        4'b0000, 32'h0,        0, 1};
    vecs[9]  = '{1'b1, 3'd4, 32'h200, 32'h1234,     32'h0,        0, 1'b0, 2'b11, 32'h0,        4'b0000, 32'h0,        0, 1};
    vecs[10] = '{1'b0, 3'd3, 32'h200, 32'h0,        32'h0,        0, 1'b0, 2'b11, 32'h0,        4'b0000, 32'h0,        0, 1};
    vecs[11] = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h55555555, -1, 1'b0, 2'b10, 32'h0,       4'b1111, 32'h0,        4, 5};
    vecs[12] = '{1'b0, 3'd2, 32'h104, 32'h0,        32'h12345678, 3, 1'b0, 2'b00, 32'h12345678, 4'b1111, 32'h0,        4, 5};
    vecs[13] = '{1'b1, 3'd1, 32'h206, 32'h1234BEEF, 32'h0,        0, 1'b0, 2'b00, 32'h0,        4'b1100, 32'hBEEFBEEF, 1, 2};
    vecs[14] = '{1'b0, 3'd0, 32'h101, 32'h0,        32'h00007F00, 0, 1'b0, 2'b00, 32'h0000007F, 4'b0010, 32'h0,        1, 2};
    vecs[15] = '{1'b0, 3'd2, 32'h108, 32'h0,        32'hCAFEF00D, 1, 1'b1, 2'b00, 32'hCAFEF00D, 4'b1111, 32'h0,        2, 3};

    // Reset values while held in reset
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run(vecs[i], i);

    // Stray rvalid while idle produces nothing
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || mem_req || !req_ready) quiet = 0;
    end
    mem_rvalid = 1'b0;
    chk("stray_rvalid_quiet", 32'(quiet), 32'd1);

    // Reset in the middle of a busy access
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10C; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_busy", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req_drop", 32'(mem_req), 32'd0);
    chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || mem_req || !req_ready) quiet = 0;
    end
    chk("midrst_quiet_after", 32'(quiet), 32'd1);
    run(vecs[12], 16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
